// File: rtl/pdm_demod.sv
// ---------------------------------------------------------------------------
// pdm_demod
//   Recovers an NBITS sample from a 1-bit PDM stream by integrate-and-dump over
//   fixed windows of 2^LOG2_WIN cycles. After SKIP_WIN settling windows, one
//   scaled, saturated sample is produced per window with a one-cycle strobe.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   en           in   1      acquisition enable; low aborts the current window
//   pdm_in       in   1      PDM bit stream, sampled every cycle in SKIP/RUN
//   dout         out  NBITS  last completed window result, held between strobes
//   valid        out  1      one-cycle strobe, dout updated on the same edge
//   busy         out  1      high in SKIP or RUN
//   dbg_state_o  out  2      current FSM state (IDLE=0, SKIP=1, RUN=2)
//
// Output protocol: valid is a pure strobe with no backpressure. The consumer
// must take dout in the cycle valid is high; dout stays stable until the next
// strobe, an abort does not touch it, and only rst clears it.
// ---------------------------------------------------------------------------
module pdm_demod #(
  parameter int NBITS    = 10,
  parameter int LOG2_WIN = 10,
  parameter int SKIP_WIN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pdm_in,
  output logic [NBITS-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int AW    = LOG2_WIN + 1;
  localparam int SHIFT = LOG2_WIN - NBITS;

  // Largest representable result, widened to the accumulator width.
  localparam logic [AW-1:0] MAXV = AW'((1 << NBITS) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [LOG2_WIN-1:0]   wcnt_q, wcnt_d;
  logic [7:0]            skip_q, skip_d;
  logic [NBITS-1:0]      dout_q, dout_d;
  logic                  valid_q, valid_d;

  logic                  win_end;
  logic [AW-1:0]         sum;
  logic [AW-1:0]         res_full;
  logic [NBITS-1:0]      res;

  assign win_end = (wcnt_q == '1);

  // The window's last bit is folded in combinationally so the result is
  // registered on the edge that samples it.
  assign sum      = acc_q + AW'(pdm_in);
  assign res_full = sum >> SHIFT;
  // An all-ones window yields 2^NBITS after scaling; clamp it to full scale.
  assign res      = (res_full > MAXV) ? '1 : res_full[NBITS-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wcnt_d  = wcnt_q;
    skip_d  = skip_q;
    dout_d  = dout_q;
    valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // pdm_in is ignored here; the en-rise cycle itself is never sampled.
        acc_d  = '0;
        wcnt_d = '0;
        skip_d = '0;
        if (en) begin
          state_d = (SKIP_WIN > 0) ? SKIP : RUN;
        end
      end

      SKIP, RUN: begin
        if (win_end) begin
          // A window that ends in the same cycle en falls still completes.
          acc_d  = '0;
          wcnt_d = '0;
          if (state_q == RUN) begin
            dout_d  = res;
            valid_d = 1'b1;
          end else if (skip_q == 8'(SKIP_WIN - 1)) begin
            state_d = RUN;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + 8'd1;
          end
          if (!en) begin
            state_d = IDLE;
            skip_d  = '0;
          end
        end else if (!en) begin
          // Abort: the partial window is dropped, dout is left untouched.
          state_d = IDLE;
          acc_d   = '0;
          wcnt_d  = '0;
          skip_d  = '0;
        end else begin
          acc_d  = sum;
          wcnt_d = wcnt_q + LOG2_WIN'(1);
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
        wcnt_d  = '0;
        skip_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      wcnt_q  <= '0;
      skip_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wcnt_q  <= wcnt_d;
      skip_q  <= skip_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout        = dout_q;
  assign valid       = valid_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pdm_demod.sv
// ---------------------------------------------------------------------------
// tb_pdm_demod
//   Two demodulators share one PDM stream and enable:
//     dut_a: NBITS=10, LOG2_WIN=10, SKIP_WIN=1 (unity gain)
//     dut_b: NBITS=8,  LOG2_WIN=10, SKIP_WIN=3 (scaled by >>2, longer settle)
//   The driver counts the ones it sends per window and, for windows that
//   should produce a strobe, pushes the expected value and strobe cycle.
//   Negedge monitors pop and compare whenever a strobe appears.
// ---------------------------------------------------------------------------
module tb_pdm_demod;

  localparam int WIN    = 1024;
  localparam int SKIP_A = 1;
  localparam int SKIP_B = 3;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_MOD  = 2;
  localparam int M_RND  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic pdm_in;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] dout_a;
  logic       valid_a, busy_a;
  logic [1:0] dbg_a;
  logic [7:0] dout_b;
  logic       valid_b, busy_b;
  logic [1:0] dbg_b;

  pdm_demod #(.NBITS(10), .LOG2_WIN(10), .SKIP_WIN(SKIP_A)) dut_a (
    .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in),
    .dout(dout_a), .valid(valid_a), .busy(busy_a), .dbg_state_o(dbg_a)
  );

  pdm_demod #(.NBITS(8), .LOG2_WIN(10), .SKIP_WIN(SKIP_B)) dut_b (
    .clk(clk), .rst(rst), .en(en), .pdm_in(pdm_in),
    .dout(dout_b), .valid(valid_b), .busy(busy_b), .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_a_q[$];
  int         cyc_a_q[$];
  logic [7:0] exp_b_q[$];
  int         cyc_b_q[$];
  logic [9:0] last_a = '0;
  logic [7:0] last_b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_a_q.size() > 0 && cyc > cyc_a_q[0]) begin
        check("a_missing_strobe_cycle", cyc, cyc_a_q[0]);
        void'(exp_a_q.pop_front());
        void'(cyc_a_q.pop_front());
      end
      if (valid_a) begin
        if (exp_a_q.size() == 0) begin
          check("a_unexpected_strobe", valid_a, 1'b0);
        end else begin
          check("a_dout", dout_a, exp_a_q.pop_front());
          check("a_strobe_cycle", cyc, cyc_a_q.pop_front());
        end
      end
      if (exp_b_q.size() > 0 && cyc > cyc_b_q[0]) begin
        check("b_missing_strobe_cycle", cyc, cyc_b_q[0]);
        void'(exp_b_q.pop_front());
        void'(cyc_b_q.pop_front());
      end
      if (valid_b) begin
        if (exp_b_q.size() == 0) begin
          check("b_unexpected_strobe", valid_b, 1'b0);
        end else begin
          check("b_dout", dout_b, exp_b_q.pop_front());
          check("b_strobe_cycle", cyc, cyc_b_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  int         mode    = M_ZERO;
  logic [9:0] din     = '0;
  logic [9:0] macc    = '0;
  int         win_idx = 0;

  // First-order sigma-delta modulator, the same kind that feeds the block.
  task automatic next_bit(output logic b);
    logic [10:0] s;
    case (mode)
      M_ONE:   b = 1'b1;
      M_MOD: begin
        s    = {1'b0, macc} + {1'b0, din};
        b    = s[10];
        macc = s[9:0];
      end
      M_RND:   b = 1'($urandom_range(0, 1));
      default: b = 1'b0;
    endcase
  endtask

  // en is raised; the edge that sees it is not a sample edge.
  task automatic start();
    en      = 1'b1;
    win_idx = 0;
    @(negedge clk);
  endtask

  // Drives nbits samples from the current window start. A full window pushes
  // its expected result when it is a RUN window for that instance.
  task automatic run_window(input int nbits, input bit drop_last,
                            input int step_at, input logic [9:0] step_din);
    int   ones;
    int   ea;
    int   eb;
    logic b;
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i == step_at) din = step_din;
      next_bit(b);
      pdm_in = b;
      ones  += int'(b);
      if (i == WIN - 1) begin
        if (drop_last) en = 1'b0;
        ea = (ones > 1023) ? 1023 : ones;
        eb = ((ones >> 2) > 255) ? 255 : (ones >> 2);
        if (win_idx >= SKIP_A) begin
          exp_a_q.push_back(10'(ea));
          cyc_a_q.push_back(cyc + 1);
          last_a = 10'(ea);
        end
        if (win_idx >= SKIP_B) begin
          exp_b_q.push_back(8'(eb));
          cyc_b_q.push_back(cyc + 1);
          last_b = 8'(eb);
        end
      end
      @(negedge clk);
    end
    if (nbits == WIN) win_idx++;
  endtask

  task automatic idle_random(input int n);
    for (int i = 0; i < n; i++) begin
      pdm_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    pdm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout_a",  dout_a,  10'd0);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_busy_a",  busy_a,  1'b0);
    check("rst_state_a", dbg_a,   2'd0);
    check("rst_dout_b",  dout_b,  8'd0);
    check("rst_busy_b",  busy_b,  1'b0);
    rst = 1'b0;
    idle_random(3);
    check("idle_busy_a", busy_a, 1'b0);

    // Modulated constant 120, first A strobe one skip window after leaving IDLE.
    mode = M_MOD; din = 10'd120; macc = '0;
    start();
    check("start_busy_a",  busy_a, 1'b1);
    check("start_state_a", dbg_a,  2'd1);
    check("start_state_b", dbg_b,  2'd1);
    repeat (2) run_window(WIN, 1'b0, -1, '0);
    check("skip_dout_b", dout_b, 8'd0);
    check("run_state_a", dbg_a,  2'd2);
    repeat (2) run_window(WIN, 1'b0, -1, '0);

    // Saturation, zero and random windows; spacing is checked by strobe cycles.
    mode = M_ONE;
    repeat (2) run_window(WIN, 1'b0, -1, '0);
    mode = M_ZERO;
    run_window(WIN, 1'b0, -1, '0);
    mode = M_RND;
    run_window(WIN, 1'b0, -1, '0);

    // Modulator step 500 -> 900 mid-window.
    mode = M_MOD; din = 10'd500;
    run_window(WIN, 1'b0, -1, '0);
    run_window(WIN, 1'b0, 512, 10'd900);
    repeat (2) run_window(WIN, 1'b0, -1, '0);
    check("after_step_in_range", (dout_a >= 10'd899 && dout_a <= 10'd901), 1'b1);

    // Abort at wcnt=700, idle 5 cycles with noise on pdm_in, then restart.
    run_window(700, 1'b0, -1, '0);
    en = 1'b0;
    idle_random(1);
    check("abort_busy_a", busy_a, 1'b0);
    check("abort_hold_a", dout_a, last_a);
    check("abort_hold_b", dout_b, last_b);
    idle_random(4);
    din = 10'd640;
    start();
    repeat (2) run_window(WIN, 1'b0, -1, '0);

    // en falls in the window-end cycle: strobe still fires, then IDLE.
    run_window(WIN, 1'b1, -1, '0);
    check("drop_end_busy_a", busy_a, 1'b0);
    check("drop_end_busy_b", busy_b, 1'b0);
    idle_random(3);

    // Asynchronous reset mid-window in RUN, then a fresh start.
    din = 10'd250;
    start();
    repeat (2) run_window(WIN, 1'b0, -1, '0);
    run_window(300, 1'b0, -1, '0);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("async_rst_dout_a",  dout_a,  10'd0);
    check("async_rst_valid_a", valid_a, 1'b0);
    check("async_rst_busy_a",  busy_a,  1'b0);
    check("async_rst_dout_b",  dout_b,  8'd0);
    check("async_rst_busy_b",  busy_b,  1'b0);
    @(negedge clk);
    rst    = 1'b0;
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    din = 10'd333; macc = '0;
    start();
    repeat (4) run_window(WIN, 1'b0, -1, '0);

    en = 1'b0;
    idle_random(3);
    check("pending_a", exp_a_q.size(), 0);
    check("pending_b", exp_b_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
